// File: rtl/btn_duty_ctrl.sv
// btn_duty_ctrl: button front end for the LED PWM duty input.
// Synchronises and debounces two raw push-buttons, turns presses and holds
// into step requests (with auto-repeat) and keeps a saturating duty register.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   button1, button2   raw brighter / dimmer pins, asynchronous to clk
//   duty               registered duty value
//   duty_valid         one-cycle pulse in the cycle duty takes a new value
//   at_max, at_min     registered limit flags, updated with duty
// Press-to-duty latency: 2 sync + DEBOUNCE_CYCLES + step register + duty register.
module btn_duty_ctrl #(
  parameter int unsigned DUTY_W          = 8,
  parameter int unsigned STEP            = 16,
  parameter int unsigned DUTY_INIT       = 128,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              button1,
  input  logic              button2,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              at_max,
  output logic              at_min
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned SUM_W   = DUTY_W + 1;

  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0]  RATE_LAST  = TMR_W'(REPEAT_RATE - 1);
  localparam logic [SUM_W-1:0]  DUTY_MAX   = {1'b0, {DUTY_W{1'b1}}};
  localparam logic [SUM_W-1:0]  STEP_X     = SUM_W'(STEP);
  localparam logic [DUTY_W-1:0] INIT_V     = DUTY_W'(DUTY_INIT);
  localparam logic [1:0]        RELEASED   = {2{BTN_ACTIVE_LOW}};

  typedef enum logic [1:0] {IDLE, WAIT, RPT, LOCK} state_e;

  // Index 0 = button1 (brighter), index 1 = button2 (dimmer).
  logic [1:0]       sync1_q, sync2_q, pressed;
  logic [1:0]       deb_q, deb_d;
  logic [DB_W-1:0]  cnt_q [2];
  logic [DB_W-1:0]  cnt_d [2];
  state_e           state_q [2];
  state_e           state_d [2];
  logic [TMR_W-1:0] tmr_q [2];
  logic [TMR_W-1:0] tmr_d [2];
  logic [1:0]       step_q, step_d;
  logic             chord;
  logic [SUM_W-1:0] sum_inc, sum_dec;
  logic [DUTY_W-1:0] duty_next;

  // Two-flop synchroniser, then polarity normalised to pressed = 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
    end else begin
      sync1_q <= {button2, button1};
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ RELEASED;

  // Debounce: flip only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (pressed[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_LAST) deb_d[i] = ~deb_q[i];
        else                     cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
  end

  assign chord = deb_q[0] & deb_q[1];

  // Per-button press/repeat FSM. IDLE is only ever entered with the debounced
  // level low, so a high level seen in IDLE is a rising edge.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      tmr_d[i]   = '0;
      step_d[i]  = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (chord) state_d[i] = LOCK;
          else if (deb_q[i]) begin
            state_d[i] = WAIT;
            step_d[i]  = 1'b1;
          end
        end
        WAIT: begin
          if (chord)                     state_d[i] = LOCK;
          else if (!deb_q[i])            state_d[i] = IDLE;
          else if (tmr_q[i] == DELAY_LAST) begin
            state_d[i] = RPT;
            step_d[i]  = 1'b1;
          end else tmr_d[i] = tmr_q[i] + TMR_W'(1);
        end
        RPT: begin
          if (chord)                    state_d[i] = LOCK;
          else if (!deb_q[i])           state_d[i] = IDLE;
          else if (tmr_q[i] == RATE_LAST) step_d[i] = 1'b1;
          else tmr_d[i] = tmr_q[i] + TMR_W'(1);
        end
        LOCK: begin
          if (!deb_q[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Debounce and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q  <= '0;
      step_q <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= IDLE;
        tmr_q[i]   <= '0;
      end
    end else begin
      deb_q  <= deb_d;
      step_q <= step_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
        tmr_q[i]   <= tmr_d[i];
      end
    end
  end

  // Saturating duty arithmetic in DUTY_W+1 bits; simultaneous inc/dec cancel.
  always_comb begin
    sum_inc   = {1'b0, duty} + STEP_X;
    sum_dec   = {1'b0, duty} - STEP_X;
    duty_next = duty;
    if (step_q[0] && !step_q[1])
      duty_next = (sum_inc > DUTY_MAX) ? DUTY_MAX[DUTY_W-1:0] : sum_inc[DUTY_W-1:0];
    else if (step_q[1] && !step_q[0])
      duty_next = sum_dec[DUTY_W] ? '0 : sum_dec[DUTY_W-1:0];
  end

  // Duty register and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty       <= INIT_V;
      duty_valid <= 1'b0;
      at_max     <= &INIT_V;
      at_min     <= ~|INIT_V;
    end else begin
      duty       <= duty_next;
      duty_valid <= (duty_next != duty);
      at_max     <= &duty_next;
      at_min     <= ~|duty_next;
    end
  end

endmodule

// File: tb/tb_btn_duty_ctrl.sv
// Directed bench for btn_duty_ctrl with short debounce/repeat timing.
module tb_btn_duty_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       button1, button2;
  logic [7:0] duty;
  logic       duty_valid, at_max, at_min;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int vcyc[$];
  int vval[$];

  btn_duty_ctrl #(
    .DUTY_W(8), .STEP(16), .DUTY_INIT(128), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20), .REPEAT_RATE(5), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button1(button1), .button2(button2),
    .duty(duty), .duty_valid(duty_valid), .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; duty_valid pulses logged with cyc and duty.
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (duty_valid) begin
    vcyc.push_back(cyc);
    vval.push_back(int'(duty));
  end

  typedef struct {
    bit b1;
    bit b2;
    int cycles;
    int duty;
    int pulses;
    bit amax;
    bit amin;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n falling edges, then settle 1 time unit.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input bit p1, input bit p2);
    button1 = ~p1;
    button2 = ~p2;
  endtask

  // Check pulses logged from index base against expected cycle offsets/values.
  task automatic chk_pulse(input string name, input int base, input int k,
                           input int exp_cyc, input int exp_val);
    if (vcyc.size() > base + k) begin
      chk($sformatf("%s_cyc%0d", name, k), vcyc[base+k], exp_cyc);
      chk($sformatf("%s_val%0d", name, k), vval[base+k], exp_val);
    end else begin
      chk($sformatf("%s_missing%0d", name, k), 0, 1);
    end
  endtask

  vec_t vecs[19];

  initial begin
    int c, base;

    // Phase table from duty = 208 (after the auto-repeat sequence).
    vecs[0]  = '{1, 0, 12, 224, 1, 0, 0};
    vecs[1]  = '{0, 0, 20, 224, 0, 0, 0};
    vecs[2]  = '{1, 0, 12, 240, 1, 0, 0};
    vecs[3]  = '{0, 0, 20, 240, 0, 0, 0};
    vecs[4]  = '{1, 0, 12, 255, 1, 1, 0};
    vecs[5]  = '{0, 0, 20, 255, 0, 1, 0};
    vecs[6]  = '{1, 0, 12, 255, 0, 1, 0};
    vecs[7]  = '{0, 0, 20, 255, 0, 1, 0};
    vecs[8]  = '{0, 1, 110,  0, 16, 0, 1};
    vecs[9]  = '{0, 1, 30,   0, 0, 0, 1};
    vecs[10] = '{0, 0, 20,   0, 0, 0, 1};
    vecs[11] = '{1, 0, 12,  16, 1, 0, 0};
    vecs[12] = '{1, 1, 40,  16, 0, 0, 0};
    vecs[13] = '{1, 0, 40,  16, 0, 0, 0};
    vecs[14] = '{1, 1, 40,  16, 0, 0, 0};
    vecs[15] = '{1, 0, 20,  16, 0, 0, 0};
    vecs[16] = '{0, 0, 20,  16, 0, 0, 0};
    vecs[17] = '{0, 1, 12,   0, 1, 0, 1};
    vecs[18] = '{0, 0, 20,   0, 0, 0, 1};

    // Reset with button1 low at the pin.
    rst_n = 1'b0;
    button1 = 1'b0;
    button2 = 1'b1;
    tick(5);
    chk("rst_duty", int'(duty), 128);
    chk("rst_valid", int'(duty_valid), 0);
    chk("rst_max", int'(at_max), 0);
    chk("rst_min", int'(at_min), 0);
    rst_n = 1'b1;
    press(0, 0);
    tick(100);
    chk("idle_duty", int'(duty), 128);
    chk("idle_pulses", vcyc.size(), 0);
    chk("idle_max", int'(at_max), 0);
    chk("idle_min", int'(at_min), 0);

    // 3-cycle glitch must be rejected.
    press(1, 0);
    tick(3);
    press(0, 0);
    tick(10);
    chk("glitch_pulses", vcyc.size(), 0);
    chk("glitch_duty", int'(duty), 128);

    // Real press: sampling edge is the 1st of 8 edges to the duty update.
    base = vcyc.size();
    c = cyc;
    press(1, 0);
    tick(12);
    press(0, 0);
    tick(30);
    chk("press_pulses", vcyc.size() - base, 1);
    chk_pulse("press", base, 0, c + 8, 144);
    chk("press_duty", int'(duty), 144);

    // Auto-repeat: steps at t, t+20, t+25, t+30; debounced release lands at t+32.
    base = vcyc.size();
    c = cyc;
    press(1, 0);
    tick(34);
    press(0, 0);
    tick(40);
    chk("rpt_pulses", vcyc.size() - base, 4);
    chk_pulse("rpt", base, 0, c + 8, 160);
    chk_pulse("rpt", base, 1, c + 28, 176);
    chk_pulse("rpt", base, 2, c + 33, 192);
    chk_pulse("rpt", base, 3, c + 38, 208);

    // Saturation and chord phases.
    for (int i = 0; i < 19; i++) begin
      base = vcyc.size();
      press(vecs[i].b1, vecs[i].b2);
      tick(vecs[i].cycles);
      chk($sformatf("vec%0d_duty", i), int'(duty), vecs[i].duty);
      chk($sformatf("vec%0d_pulses", i), vcyc.size() - base, vecs[i].pulses);
      chk($sformatf("vec%0d_max", i), int'(at_max), int'(vecs[i].amax));
      chk($sformatf("vec%0d_min", i), int'(at_min), int'(vecs[i].amin));
    end

    // Reset asserted while button1 is auto-repeating.
    press(1, 0);
    tick(45);
    chk("prerst_duty", int'(duty), 80);
    rst_n = 1'b0;
    #1;
    chk("midrst_duty", int'(duty), 128);
    chk("midrst_valid", int'(duty_valid), 0);
    chk("midrst_min", int'(at_min), 0);
    tick(3);
    base = vcyc.size();
    c = cyc;
    rst_n = 1'b1;
    tick(40);
    chk("postrst_pulses", vcyc.size() - base, 4);
    chk_pulse("postrst", base, 0, c + 8, 144);
    chk_pulse("postrst", base, 1, c + 28, 160);
    chk_pulse("postrst", base, 2, c + 33, 176);
    chk_pulse("postrst", base, 3, c + 38, 192);
    press(0, 0);
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_duty_ctrl.md
Name: btn_duty_ctrl

Overview:
- Front-end control stage that feeds the LED PWM generator.
- Takes the two raw board push-buttons (brighter / dimmer), synchronises and debounces them, and turns presses and holds into step requests.
- Maintains a saturating duty-cycle register that drives the PWM stage's duty input.
- Reports when the duty value changes and when it is pinned at either limit.

Parameters:
- DUTY_W, 8, width of duty output.
- STEP, 16, duty increment/decrement per step (1..2^DUTY_W-1).
- DUTY_INIT, 128, duty value after reset.
- DEBOUNCE_CYCLES, 1000000, cycles a synchronised input must differ from the debounced state before the debounced state flips (20 ms at 50 MHz); minimum 2.
- REPEAT_DELAY, 25000000, cycles from first step to first auto-repeat step while held.
- REPEAT_RATE, 5000000, cycles between subsequent auto-repeat steps.
- BTN_ACTIVE_LOW, 1, 1 = pressed button reads 0 at the pin.

Ports:
- clk  in  1  board oscillator clock
- rst_n  in  1  asynchronous active-low reset
- button1  in  1  raw brighter button, asynchronous to clk
- button2  in  1  raw dimmer button, asynchronous to clk
- duty  out  DUTY_W  registered duty value to the PWM stage
- duty_valid  out  1  one-cycle pulse, asserted the same cycle duty takes a new value
- at_max  out  1  duty == 2^DUTY_W-1 (registered)
- at_min  out  1  duty == 0 (registered)

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. While rst_n=0: duty=DUTY_INIT, duty_valid=0, at_max/at_min reflect DUTY_INIT, sync flops=released level, debounced state=released, all counters=0, FSMs=IDLE. Reset asserted mid-hold aborts all activity. After release, a still-held button is seen as a fresh press once debounced.
- Sync: each button passes through a 2-FF synchroniser, then polarity is normalised so pressed=1.
- Debounce (per button): a counter increments each cycle the synchronised value differs from the debounced value and clears to 0 on any match. The debounced value flips on the edge where the count would reach DEBOUNCE_CYCLES, and the counter clears. Glitches shorter than DEBOUNCE_CYCLES never propagate.
- Per-button FSM states:
  - IDLE: on debounced rise go to WAIT and emit a 1-cycle step pulse; the timer loads 0.
  - WAIT: the timer counts. At REPEAT_DELAY-1, emit a step, go to RPT, clear the timer.
  - RPT: emit a step every REPEAT_RATE cycles.
  - Debounced fall in WAIT or RPT: return to IDLE with no step.
  - LOCK: entered from any state when both debounced values are 1 in the same cycle; no steps or timing. Exit to IDLE only on this button's debounced fall. Re-pressing one button while the other is still held keeps both in LOCK.
- Step pulses are registered. duty updates on the cycle after the step pulse.
- Latency: duty changes exactly 2 + DEBOUNCE_CYCLES + 2 cycles after the first clk edge that samples the new raw level.
- Arithmetic: computed in DUTY_W+1 bits.
  - Increment: duty = min(duty+STEP, 2^DUTY_W-1).
  - Decrement: duty = max(duty-STEP, 0).
  - Inc and dec steps in the same cycle cancel: no change, no duty_valid.
- duty_valid pulses only if the new value differs from the old. A step while already at a limit gives no pulse and no change.
- at_max/at_min update in the same cycle as duty.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, STEP=16, DUTY_W=8, DUTY_INIT=128, active-low pins):
- Reset check: hold rst_n=0 with button1=0, then release, buttons idle for 100 cycles -> duty=128, duty_valid never high, at_max=at_min=0.
- Single press and bounce rejection: button1 low for 3 cycles, high for 10, then low for 12, then high -> no change from the 3-cycle glitch; duty=144 with one duty_valid pulse exactly 8 cycles after the low level is first sampled.
- Auto-repeat: hold button1 from first step at cycle t -> duty 144@t, 160@t+20, 176@t+25, 192@t+30; releasing at t+32 -> no further steps.
- Saturation: from 240, one button1 step -> 255 with valid and at_max=1; another step -> 255, no valid. Hold button2 from 16 -> 0 with at_min=1, no further valid.
- Chord: press button1, then button2 while button1 is still held -> no further change after button1's initial step; release button2 while holding button1 -> no steps; release both, press button2 -> single decrement.
- Reset mid-hold: assert rst_n=0 during RPT -> duty=128 immediately (asynchronous); release rst_n with button1 still held -> one step to 144 after debounce, then normal repeat timing.
